// File: rtl/muldiv_hilo.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_hilo
// Purpose  : Iterative multiply/divide unit with the HI/LO register pair.
//            A multiply runs as 32 shift-add steps. A divide runs as 32
//            restoring shift-subtract steps. One sign-fix cycle follows, and
//            only that cycle writes HI/LO. MTHI/MTLO write HI/LO in one cycle.
// Ports    : clk        - system clock, rising edge
//            reset      - synchronous active-high reset
//            alucontrol - operation code from the ALU decoder
//            start      - one-cycle request, honoured only when idle
//            srca/srcb  - rs/rt operands
//            busy       - high while an operation is in flight
//            done       - one-cycle pulse; HI/LO hold the new result
//            hi/lo      - HI and LO registers
//            result     - hi for MFHI, lo for MFLO, otherwise zero
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       alucontrol,
    input  logic             start,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] result
);

    localparam logic [4:0] c_OP_MULTU = 5'b00111;
    localparam logic [4:0] c_OP_MULT  = 5'b01000;
    localparam logic [4:0] c_OP_DIV   = 5'b01111;
    localparam logic [4:0] c_OP_DIVU  = 5'b10000;
    localparam logic [4:0] c_OP_MTHI  = 5'b10001;
    localparam logic [4:0] c_OP_MTLO  = 5'b10010;
    localparam logic [4:0] c_OP_MFHI  = 5'b11010;
    localparam logic [4:0] c_OP_MFLO  = 5'b11011;

    localparam int              c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_CW-1:0]      r_cnt;
    // Multiply: upper half holds the partial product and the lower half
    // holds the multiplier as it shifts out. Divide: upper half holds the
    // partial remainder and the lower half holds the dividend as it shifts
    // out. Quotient bits shift in from the bottom.
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_mcand;     // multiplicand or divisor magnitude
    logic                 r_neg_q;     // negate product / quotient
    logic                 r_neg_r;     // negate remainder (dividend sign)
    logic                 r_is_div;
    logic                 r_div_zero;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;

    // ------------------------------------------------------------------
    // Operand conditioning at the start edge
    // ------------------------------------------------------------------
    logic             w_is_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_is_signed = (alucontrol == c_OP_MULT) || (alucontrol == c_OP_DIV);
    assign w_a_neg     = w_is_signed & srca[WIDTH-1];
    assign w_b_neg     = w_is_signed & srcb[WIDTH-1];
    assign w_a_mag     = w_a_neg ? -srca : srca;
    assign w_b_mag     = w_b_neg ? -srcb : srcb;

    // ------------------------------------------------------------------
    // One multiply step: add the multiplicand when the multiplier LSB is
    // set, then shift the whole accumulator right. The carry bit enters
    // at the top.
    // ------------------------------------------------------------------
    logic [WIDTH:0] w_mul_sum;

    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});

    // ------------------------------------------------------------------
    // One restoring divide step. The next dividend bit shifts into the
    // remainder. The step subtracts only when the divisor fits.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_diff;
    logic [WIDTH-1:0] w_div_rem;

    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_mcand});
    // When the divisor fits, the difference is below 2^WIDTH, so the
    // narrow subtraction is exact.
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_mcand;
    assign w_div_rem   = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];

    // ------------------------------------------------------------------
    // Sign correction applied in the FIX cycle
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    // With a zero divisor, every step "fits". The remainder then collects
    // the dividend magnitude unchanged. After the sign fix it equals srca,
    // so no separate copy of srca is kept.
    assign w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // ------------------------------------------------------------------
    // Control and datapath state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_is_div   <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (alucontrol)
                            c_OP_MTHI: r_hi <= srca;
                            c_OP_MTLO: r_lo <= srca;
                            c_OP_MULTU, c_OP_MULT: begin
                                r_acc      <= {{WIDTH{1'b0}}, w_b_mag};
                                r_mcand    <= w_a_mag;
                                r_neg_q    <= w_a_neg ^ w_b_neg;
                                r_neg_r    <= w_a_neg;
                                r_is_div   <= 1'b0;
                                r_div_zero <= 1'b0;
                                r_cnt      <= '0;
                                r_state    <= S_MUL;
                            end
                            c_OP_DIV, c_OP_DIVU: begin
                                r_acc      <= {{WIDTH{1'b0}}, w_a_mag};
                                r_mcand    <= w_b_mag;
                                r_neg_q    <= w_a_neg ^ w_b_neg;
                                r_neg_r    <= w_a_neg;
                                r_is_div   <= 1'b1;
                                r_div_zero <= (srcb == '0);
                                r_cnt      <= '0;
                                r_state    <= S_DIV;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= S_FIX;
                    end
                end
                S_DIV: begin
                    r_acc <= {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= r_div_zero ? {WIDTH{1'b1}} : w_quo_fix;
                    end else begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

    always_comb begin
        result = '0;
        case (alucontrol)
            c_OP_MFHI: result = r_hi;
            c_OP_MFLO: result = r_lo;
            default:   result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_hilo.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_hilo
// Purpose  : Directed self-checking bench for muldiv_hilo. The vectors carry
//            hand-computed HI/LO values. Each operation also has its
//            latency, busy length and done-cycle busy checked.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_hilo;

    localparam logic [4:0] c_MULTU = 5'b00111;
    localparam logic [4:0] c_MULT  = 5'b01000;
    localparam logic [4:0] c_DIV   = 5'b01111;
    localparam logic [4:0] c_DIVU  = 5'b10000;
    localparam logic [4:0] c_MTHI  = 5'b10001;
    localparam logic [4:0] c_MTLO  = 5'b10010;
    localparam logic [4:0] c_MFHI  = 5'b11010;
    localparam logic [4:0] c_MFLO  = 5'b11011;

    logic        clk;
    logic        reset;
    logic [4:0]  alucontrol;
    logic        start;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_hilo #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .alucontrol (alucontrol),
        .start      (start),
        .srca       (srca),
        .srcb       (srcb),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one multiply/divide and follow it to completion. With now=1 the
    // request goes out at the current negedge, which is the previous done
    // cycle. With inject=1 a MTLO request arrives mid-flight.
    task automatic run_op(input string tag, input logic [4:0] code,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input bit now, input bit inject);
        int cyc;
        int bcnt;
        logic [31:0] lo_hold;
        if (!now) @(negedge clk);
        start      = 1'b1;
        alucontrol = code;
        srca       = a;
        srcb       = b;
        @(posedge clk);
        #1;
        start      = 1'b0;
        alucontrol = 5'($urandom_range(0, 31));
        srca       = $urandom;
        srcb       = $urandom;
        lo_hold    = lo;
        cyc        = 0;
        bcnt       = 0;
        @(negedge clk);
        while (!done && cyc < 100) begin
            if (busy) bcnt++;
            if (inject && cyc == 5) begin
                start      = 1'b1;
                alucontrol = c_MTLO;
                srca       = 32'hDEADBEEF;
            end else if (inject && cyc == 6) begin
                start = 1'b0;
                check({tag, "_mtlo_busy"}, {32'd0, lo}, {32'd0, lo_hold});
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'd33);
        check({tag, "_busy_len"}, 64'(bcnt), 64'd33);
        check({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        reset      = 1'b1;
        start      = 1'b0;
        alucontrol = c_MFHI;
        srca       = '0;
        srcb       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hi",     {32'd0, hi},     64'd0);
        check("rst_lo",     {32'd0, lo},     64'd0);
        check("rst_busy",   {63'd0, busy},   64'd0);
        check("rst_done",   {63'd0, done},   64'd0);
        check("rst_result", {32'd0, result}, 64'd0);
        reset = 1'b0;

        // Directed arithmetic vectors
        run_op("multu_max", c_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
        // Request made in the done cycle of the previous operation
        run_op("mult_m3x5", c_MULT, 32'hFFFFFFFD, 32'd5,
               32'hFFFFFFFF, 32'hFFFFFFF1, 1'b1, 1'b0);
        run_op("div_m7d2", c_DIV, 32'hFFFFFFF9, 32'd2,
               32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        run_op("divu_by0", c_DIVU, 32'd100, 32'd0,
               32'd100, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("div_min_m1", c_DIV, 32'h80000000, 32'hFFFFFFFF,
               32'h00000000, 32'h80000000, 1'b0, 1'b0);
        run_op("divu_100d7", c_DIVU, 32'd100, 32'd7,
               32'd2, 32'd14, 1'b0, 1'b0);
        run_op("div_7dm2", c_DIV, 32'd7, 32'hFFFFFFFE,
               32'd1, 32'hFFFFFFFD, 1'b0, 1'b0);
        run_op("div_m5d0", c_DIV, 32'hFFFFFFFB, 32'd0,
               32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("mult_maxmin", c_MULT, 32'h7FFFFFFF, 32'h80000000,
               32'hC0000000, 32'h80000000, 1'b0, 1'b0);
        run_op("multu_inj", c_MULTU, 32'h12345678, 32'h00000010,
               32'h00000001, 32'h23456780, 1'b0, 1'b1);

        // MTHI / MTLO and the MF read mux
        @(negedge clk);
        start = 1'b1; alucontrol = c_MTHI; srca = 32'h12345678;
        @(posedge clk);
        #1;
        start = 1'b0; alucontrol = c_MFHI;
        @(negedge clk);
        check("mthi_hi",    {32'd0, hi},     {32'd0, 32'h12345678});
        check("mthi_lo",    {32'd0, lo},     {32'd0, 32'h23456780});
        check("mthi_busy",  {63'd0, busy},   64'd0);
        check("mthi_done",  {63'd0, done},   64'd0);
        check("mfhi_res",   {32'd0, result}, {32'd0, 32'h12345678});
        alucontrol = c_MFLO;
        #1;
        check("mflo_res",   {32'd0, result}, {32'd0, 32'h23456780});
        alucontrol = c_MULT;
        #1;
        check("other_res",  {32'd0, result}, 64'd0);

        @(negedge clk);
        start = 1'b1; alucontrol = c_MTLO; srca = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("mtlo_lo",    {32'd0, lo},     {32'd0, 32'hCAFEF00D});
        check("mtlo_hi",    {32'd0, hi},     {32'd0, 32'h12345678});

        // An unknown opcode with start is ignored
        @(negedge clk);
        start = 1'b1; alucontrol = 5'b00000; srca = 32'h00000055;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("nop_busy",   {63'd0, busy},   64'd0);
        check("nop_hi",     {32'd0, hi},     {32'd0, 32'h12345678});
        check("nop_lo",     {32'd0, lo},     {32'd0, 32'hCAFEF00D});

        // Reset in the middle of a DIVU aborts it without touching HI/LO
        @(negedge clk);
        start = 1'b1; alucontrol = c_DIVU; srca = 32'd1000; srcb = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", {63'd0, busy},   64'd0);
        check("abort_hi",   {32'd0, hi},     64'd0);
        check("abort_lo",   {32'd0, lo},     64'd0);
        check("abort_done", {63'd0, done},   64'd0);
        reset = 1'b0;
        dcnt  = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("abort_nodone", 64'(dcnt), 64'd0);

        run_op("multu_6x7", c_MULTU, 32'd6, 32'd7,
               32'd0, 32'd42, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_hilo.md
MULDIV_HILO -- requirements
Module: muldiv_hilo

Interface
REQ-001 Parameter: WIDTH, 32, operand/HI/LO width; all values below assume 32.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 alucontrol  input  5  operation code from the ALU decoder.
REQ-005 start  input  1  single-cycle request to execute alucontrol; asserted by control in the execute state.
REQ-006 srca  input  32  rs operand (dividend/multiplicand; source for MTHI/MTLO).
REQ-007 srcb  input  32  rt operand (divisor/multiplier).
REQ-008 busy  output  1  high while a multiply/divide is iterating.
REQ-009 done  output  1  one-cycle pulse; HI/LO hold the new result in this cycle.
REQ-010 hi  output  32  HI register.
REQ-011 lo  output  32  LO register.
REQ-012 result  output  32  combinational: hi for 5'b11010 (MFHI), lo for 5'b11011 (MFLO), else 0.

Function
REQ-013 Opcodes: MULTU 00111, MULT 01000, DIV 01111, DIVU 10000, MTHI 10001, MTLO 10010; all other codes with start are ignored.
REQ-014 FSM states: IDLE, MUL, DIV, FIX; start is honoured only in IDLE.
REQ-015 IDLE + start + MTHI: hi <= srca at that edge; lo, FSM and done unchanged; no busy.
REQ-016 IDLE + start + MTLO: lo <= srca at that edge; hi, FSM and done unchanged; no busy.
REQ-017 IDLE + start + mult/div code (edge E0): latch |srca| and |srcb| (magnitudes for signed ops, raw for unsigned), latch result sign(s) and op, clear counter, go to MUL or DIV.
REQ-018 MUL: 32 iterations, one per edge (E1..E32), shift-add into a 64-bit accumulator; then FIX.
REQ-019 DIV: 32 iterations, one per edge (E1..E32), restoring shift-subtract (quotient bit set when partial remainder >= divisor); then FIX.
REQ-020 FIX (edge E33): apply sign correction, write hi/lo, go to IDLE; done = 1 for exactly the cycle after E33.
REQ-021 busy = 1 in MUL, DIV and FIX; busy = 0 in IDLE, including the done cycle.
REQ-022 MULT/MULTU: {hi,lo} = 64-bit signed/unsigned product; signed product is negated when the operand signs differ.
REQ-023 DIV/DIVU: lo = quotient, hi = remainder; signed quotient truncates toward zero; signed remainder takes the sign of srca.
REQ-024 Divisor zero (DIV or DIVU): full latency still applies; hi = srca, lo = 32'hFFFFFFFF.
REQ-025 DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (wraps, no trap).
REQ-026 start while busy (any code, including MTHI/MTLO): ignored; in-flight operands and op are unaffected.
REQ-027 hi/lo change only at E33, on MTHI/MTLO, or on reset; they hold during iteration.
REQ-028 srca/srcb/alucontrol are don't-care after E0.
REQ-029 start in the done cycle is accepted as a new request.

Reset
REQ-030 reset high at an edge: state = IDLE, counter = 0, hi = 0, lo = 0, busy = 0, done = 0.
REQ-031 Reset takes priority over start and aborts any in-flight operation; no partial write to hi/lo.
REQ-032 Normal operation resumes on the first edge after reset deasserts.

Verification
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done 33 cycles after the start edge, busy high for 33 cycles; hi = 0xFFFFFFFE, lo = 0x00000001.
REQ-034 MULT -3 x 5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1; DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
REQ-035 DIVU 100 / 0 -> hi = 100, lo = 0xFFFFFFFF after full latency; DIV 0x80000000 / -1 -> lo = 0x80000000, hi = 0.
REQ-036 MTHI 0x12345678, then MFLO/MFHI codes -> hi updated next edge, result = 0x12345678 for MFHI; MTLO during busy -> lo unchanged.
REQ-037 reset asserted at iteration 10 of a DIVU -> next cycle busy = 0, hi = lo = 0, done never pulses; a following MULTU 6 x 7 -> lo = 42, hi = 0.
